// File: rtl/reservoir_monitor.sv
// rtl/reservoir_monitor.sv - per-day reservoir level FSM with hysteresis/debounce, flood alarm and saturating totals
module reservoir_monitor #(
  parameter int unsigned LOW_TH   = 40,
  parameter int unsigned HIGH_TH  = 200,
  parameter int unsigned FLOOD_TH = 240,
  parameter int unsigned HYST     = 8,
  parameter int unsigned CONFIRM  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample,
  input  logic        clear,
  input  logic [7:0]  now,
  input  logic [7:0]  out,
  input  logic [7:0]  electric,
  output logic [1:0]  level_state,
  output logic        alarm,
  output logic [15:0] energy_total,
  output logic [15:0] spill_total,
  output logic [7:0]  peak_level,
  output logic [7:0]  day_count,
  output logic        state_chg
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'b00,
    ST_LOW    = 2'b01,
    ST_HIGH   = 2'b10,
    ST_FLOOD  = 2'b11
  } state_t;

  // 9-bit thresholds so LOW_TH+HYST cannot wrap against an 8-bit level
  localparam logic [8:0] LOW_LIM   = 9'(LOW_TH);
  localparam logic [8:0] LOW_EXIT  = 9'(LOW_TH + HYST);
  localparam logic [8:0] HIGH_LIM  = 9'(HIGH_TH);
  localparam logic [8:0] HIGH_EXIT = 9'(HIGH_TH - HYST);
  localparam logic [8:0] FLOOD_LIM = 9'(FLOOD_TH);
  localparam logic [8:0] FLOOD_EXIT = 9'(FLOOD_TH - HYST);
  localparam logic [3:0] CONFIRM_N = 4'(CONFIRM);

  state_t      state_q, state_d;
  state_t      pend_q, pend_d;
  state_t      tgt;
  logic [3:0]  cnt_q, cnt_d;
  logic        alarm_q, alarm_d;
  logic        chg_q, chg_d;
  logic [15:0] energy_q, energy_d;
  logic [15:0] spill_q, spill_d;
  logic [7:0]  peak_q, peak_d;
  logic [7:0]  day_q, day_d;
  logic [8:0]  lvl;
  logic [16:0] energy_sum;
  logic [16:0] spill_sum;
  logic [3:0]  cnt_inc;

  always_comb begin
    lvl = {1'b0, now};
    tgt = state_q;
    if (lvl >= FLOOD_LIM) begin
      tgt = ST_FLOOD;
    end else begin
      case (state_q)
        ST_FLOOD:  tgt = (lvl < FLOOD_EXIT) ? ST_HIGH : ST_FLOOD;
        ST_HIGH:   tgt = (lvl < HIGH_EXIT) ? ST_NORMAL : ST_HIGH;
        ST_LOW:    tgt = (lvl > LOW_EXIT) ? ST_NORMAL : ST_LOW;
        default: begin
          if (lvl >= HIGH_LIM)     tgt = ST_HIGH;
          else if (lvl <= LOW_LIM) tgt = ST_LOW;
          else                     tgt = ST_NORMAL;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 4'd1;
    if (sample) begin
      if (tgt == state_q) begin
        cnt_d = 4'd0;
      end else if (tgt == ST_FLOOD || state_q == ST_FLOOD) begin
        state_d = tgt;
        cnt_d   = 4'd0;
      end else if (tgt != pend_q || cnt_q == 4'd0) begin
        pend_d = tgt;
        cnt_d  = 4'd1;
        if (CONFIRM_N == 4'd1) begin
          state_d = tgt;
          cnt_d   = 4'd0;
        end
      end else if (cnt_inc >= CONFIRM_N) begin
        state_d = tgt;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
    alarm_d = (state_d == ST_FLOOD);
    chg_d   = (state_d != state_q);
  end

  always_comb begin
    energy_sum = {1'b0, energy_q} + {9'd0, electric};
    spill_sum  = {1'b0, spill_q} + {9'd0, out};
    energy_d   = energy_q;
    spill_d    = spill_q;
    peak_d     = peak_q;
    day_d      = day_q;
    // clear wins over a coincident sample for the statistics only
    if (clear) begin
      energy_d = 16'd0;
      spill_d  = 16'd0;
      peak_d   = 8'd0;
      day_d    = 8'd0;
    end else if (sample) begin
      energy_d = energy_sum[16] ? 16'hFFFF : energy_sum[15:0];
      spill_d  = spill_sum[16] ? 16'hFFFF : spill_sum[15:0];
      peak_d   = (now > peak_q) ? now : peak_q;
      day_d    = day_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_NORMAL;
      pend_q   <= ST_NORMAL;
      cnt_q    <= 4'd0;
      alarm_q  <= 1'b0;
      chg_q    <= 1'b0;
      energy_q <= 16'd0;
      spill_q  <= 16'd0;
      peak_q   <= 8'd0;
      day_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      alarm_q  <= alarm_d;
      chg_q    <= chg_d;
      energy_q <= energy_d;
      spill_q  <= spill_d;
      peak_q   <= peak_d;
      day_q    <= day_d;
    end
  end

  assign level_state  = state_q;
  assign alarm        = alarm_q;
  assign energy_total = energy_q;
  assign spill_total  = spill_q;
  assign peak_level   = peak_q;
  assign day_count    = day_q;
  assign state_chg    = chg_q;

endmodule

// File: tb/tb_reservoir_monitor.sv
// tb/tb_reservoir_monitor.sv - directed self-checking bench for reservoir_monitor
module tb_reservoir_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  now = 8'd0;
  logic [7:0]  out = 8'd0;
  logic [7:0]  electric = 8'd0;
  logic [1:0]  level_state;
  logic        alarm;
  logic [15:0] energy_total;
  logic [15:0] spill_total;
  logic [7:0]  peak_level;
  logic [7:0]  day_count;
  logic        state_chg;

  int checks = 0;
  int errors = 0;

  reservoir_monitor dut (
    .clk(clk), .rst(rst), .sample(sample), .clear(clear),
    .now(now), .out(out), .electric(electric),
    .level_state(level_state), .alarm(alarm),
    .energy_total(energy_total), .spill_total(spill_total),
    .peak_level(peak_level), .day_count(day_count), .state_chg(state_chg)
  );

  always #5 clk = ~clk;

  // one sample, back-to-back when called consecutively; returns 1 time unit after the edge
  task automatic samp(input logic [7:0] n, input logic [7:0] o, input logic [7:0] e);
    @(negedge clk);
    sample = 1'b1; now = n; out = o; electric = e;
    @(posedge clk);
    #1;
    sample = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_state(input string name, input logic [1:0] exp_st, input logic exp_chg);
    checks++;
    if (level_state !== exp_st) begin
      errors++;
      $display("FAIL %s level_state got %b want %b", name, level_state, exp_st);
    end
    checks++;
    if (state_chg !== exp_chg) begin
      errors++;
      $display("FAIL %s state_chg got %b want %b", name, state_chg, exp_chg);
    end
    checks++;
    if (alarm !== (exp_st == 2'b11)) begin
      errors++;
      $display("FAIL %s alarm got %b want %b", name, alarm, (exp_st == 2'b11));
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({level_state, alarm, state_chg, energy_total, spill_total, peak_level, day_count} !== 44'd0) begin
      errors++;
      $display("FAIL reset outputs got %h want 0",
               {level_state, alarm, state_chg, energy_total, spill_total, peak_level, day_count});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_normal;
    for (int i = 0; i < 3; i++) begin
      samp(8'd100, 8'd1, 8'd2);
      chk_state("normal", 2'b00, 1'b0);
    end
    checks++;
    if (day_count !== 8'd3) begin errors++; $display("FAIL normal day_count got %0d want 3", day_count); end
    checks++;
    if (energy_total !== 16'd6) begin errors++; $display("FAIL normal energy got %0d want 6", energy_total); end
    checks++;
    if (spill_total !== 16'd3) begin errors++; $display("FAIL normal spill got %0d want 3", spill_total); end
    checks++;
    if (peak_level !== 8'd100) begin errors++; $display("FAIL normal peak got %0d want 100", peak_level); end
  endtask

  task automatic test_high;
    samp(8'd210, 8'd0, 8'd0); chk_state("high_1", 2'b00, 1'b0);
    samp(8'd210, 8'd0, 8'd0); chk_state("high_2", 2'b00, 1'b0);
    samp(8'd210, 8'd0, 8'd0); chk_state("high_3", 2'b10, 1'b1);
    idle(1);                  chk_state("high_pulse_end", 2'b10, 1'b0);
    samp(8'd210, 8'd0, 8'd0); chk_state("hx_210", 2'b10, 1'b0);
    samp(8'd195, 8'd0, 8'd0); chk_state("hx_195", 2'b10, 1'b0);
    samp(8'd210, 8'd0, 8'd0); chk_state("hx_210b", 2'b10, 1'b0);
    samp(8'd191, 8'd0, 8'd0); chk_state("hx_191a", 2'b10, 1'b0);
    samp(8'd191, 8'd0, 8'd0); chk_state("hx_191b", 2'b10, 1'b0);
    samp(8'd191, 8'd0, 8'd0); chk_state("hx_191c", 2'b00, 1'b1);
  endtask

  task automatic test_flood;
    samp(8'd245, 8'd0, 8'd0); chk_state("flood_in", 2'b11, 1'b1);
    samp(8'd233, 8'd0, 8'd0); chk_state("flood_233", 2'b11, 1'b0);
    samp(8'd232, 8'd0, 8'd0); chk_state("flood_232", 2'b11, 1'b0);
    samp(8'd231, 8'd0, 8'd0); chk_state("flood_231", 2'b10, 1'b1);
    samp(8'd240, 8'd0, 8'd0); chk_state("flood_240", 2'b11, 1'b1);
    samp(8'd100, 8'd0, 8'd0); chk_state("flood_out", 2'b10, 1'b1);
    // a gap between qualifying samples keeps the debounce count
    samp(8'd100, 8'd0, 8'd0); chk_state("gap_1", 2'b10, 1'b0);
    idle(3);
    samp(8'd100, 8'd0, 8'd0); chk_state("gap_2", 2'b10, 1'b0);
    samp(8'd100, 8'd0, 8'd0); chk_state("gap_3", 2'b00, 1'b1);
  endtask

  task automatic test_low;
    samp(8'd40, 8'd0, 8'd0); chk_state("low_40a", 2'b00, 1'b0);
    samp(8'd40, 8'd0, 8'd0); chk_state("low_40b", 2'b00, 1'b0);
    samp(8'd41, 8'd0, 8'd0); chk_state("low_41", 2'b00, 1'b0);
    samp(8'd40, 8'd0, 8'd0); chk_state("low_40c", 2'b00, 1'b0);
    samp(8'd40, 8'd0, 8'd0); chk_state("low_40d", 2'b00, 1'b0);
    samp(8'd40, 8'd0, 8'd0); chk_state("low_40e", 2'b01, 1'b1);
    samp(8'd48, 8'd0, 8'd0); chk_state("low_48", 2'b01, 1'b0);
    samp(8'd49, 8'd0, 8'd0); chk_state("low_49a", 2'b01, 1'b0);
    samp(8'd48, 8'd0, 8'd0); chk_state("low_48b", 2'b01, 1'b0);
    samp(8'd49, 8'd0, 8'd0); chk_state("low_49b", 2'b01, 1'b0);
    samp(8'd49, 8'd0, 8'd0); chk_state("low_49c", 2'b01, 1'b0);
    samp(8'd49, 8'd0, 8'd0); chk_state("low_49d", 2'b00, 1'b1);
  endtask

  task automatic test_stats;
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++;
    if ({energy_total, spill_total, peak_level, day_count} !== 48'd0) begin
      errors++;
      $display("FAIL clear_alone got %h want 0", {energy_total, spill_total, peak_level, day_count});
    end
    for (int i = 0; i < 300; i++) begin
      samp((i == 77) ? 8'd150 : 8'd100, 8'd200, 8'd255);
      if (i == 255) begin
        checks++;
        if (day_count !== 8'd0) begin errors++; $display("FAIL day_wrap got %0d want 0", day_count); end
        checks++;
        if (energy_total !== 16'd65280) begin errors++; $display("FAIL energy_256 got %0d want 65280", energy_total); end
      end
      if (i == 256) begin
        checks++;
        if (energy_total !== 16'd65535) begin errors++; $display("FAIL energy_257 got %0d want 65535", energy_total); end
      end
    end
    checks++;
    if (energy_total !== 16'd65535) begin errors++; $display("FAIL energy_sat got %0d want 65535", energy_total); end
    checks++;
    if (spill_total !== 16'd60000) begin errors++; $display("FAIL spill_300 got %0d want 60000", spill_total); end
    checks++;
    if (day_count !== 8'd44) begin errors++; $display("FAIL day_300 got %0d want 44", day_count); end
    checks++;
    if (peak_level !== 8'd150) begin errors++; $display("FAIL peak got %0d want 150", peak_level); end
    chk_state("stats_state", 2'b00, 1'b0);
  endtask

  task automatic test_clear_with_sample;
    @(negedge clk);
    clear = 1'b1;
    sample = 1'b1; now = 8'd210; out = 8'd9; electric = 8'd9;
    @(posedge clk);
    #1;
    clear = 1'b0;
    sample = 1'b0;
    checks++;
    if ({energy_total, spill_total, peak_level, day_count} !== 48'd0) begin
      errors++;
      $display("FAIL clear_sample got %h want 0", {energy_total, spill_total, peak_level, day_count});
    end
    samp(8'd210, 8'd0, 8'd0); chk_state("clr_fsm_2", 2'b00, 1'b0);
    samp(8'd210, 8'd0, 8'd0); chk_state("clr_fsm_3", 2'b10, 1'b1);
    checks++;
    if (day_count !== 8'd2) begin errors++; $display("FAIL clr_day got %0d want 2", day_count); end
    samp(8'd191, 8'd0, 8'd0);
    samp(8'd191, 8'd0, 8'd0);
    samp(8'd191, 8'd0, 8'd0); chk_state("clr_back_normal", 2'b00, 1'b1);
  endtask

  task automatic test_reset_mid;
    samp(8'd30, 8'd5, 8'd5);
    samp(8'd30, 8'd5, 8'd5);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({level_state, alarm, state_chg, energy_total, spill_total, peak_level, day_count} !== 44'd0) begin
      errors++;
      $display("FAIL reset_mid got %h want 0",
               {level_state, alarm, state_chg, energy_total, spill_total, peak_level, day_count});
    end
    @(negedge clk);
    rst = 1'b1;
    samp(8'd30, 8'd0, 8'd0); chk_state("rst_low_1", 2'b00, 1'b0);
    samp(8'd30, 8'd0, 8'd0); chk_state("rst_low_2", 2'b00, 1'b0);
    samp(8'd30, 8'd0, 8'd0); chk_state("rst_low_3", 2'b01, 1'b1);
  endtask

  initial begin
    test_reset;
    test_normal;
    test_high;
    test_flood;
    test_low;
    test_stats;
    test_clear_with_sample;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
